ext_tid_alloc: RTL and testbench
================================

EXT_TID_ALLOC -- requirements
Module: ext_tid_alloc

Interface
REQ-001 SHALL have parameter NB_TID, default 16, number of transaction IDs in the pool, range 1..2^EXT_TID_WIDTH.
REQ-002 SHALL have parameter EXT_TID_WIDTH, default 4, width of a transaction ID.
REQ-003 SHALL have parameter CNT_WIDTH, default EXT_TID_WIDTH+1, width of the outstanding counter and limit.
REQ-004 clk_i  input  1  clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 limit_i  input  CNT_WIDTH  maximum outstanding IDs; values above NB_TID are treated as NB_TID.
REQ-007 alloc_req_i  input  1  requester consumes tid_o this cycle; meaningful only while valid_tid_o=1.
REQ-008 valid_tid_o  output  1  a free ID is available and the limit is not reached.
REQ-009 tid_o  output  EXT_TID_WIDTH  lowest-index free ID.
REQ-010 release_req_i  input  1  one ID completes this cycle (last read beat accepted).
REQ-011 release_tid_i  input  EXT_TID_WIDTH  ID being released.
REQ-012 outstanding_o  output  CNT_WIDTH  number of currently allocated IDs.
REQ-013 idle_o  output  1  high when outstanding_o=0.
REQ-014 err_o  output  1  sticky release error; exists only under the macro, otherwise tied 0.
REQ-015 err_clr_i  input  1  synchronous clear of err_o.

Function
REQ-016 SHALL hold an NB_TID-bit busy bitmap and a CNT_WIDTH outstanding counter as its only state, plus err_o.
REQ-017 valid_tid_o SHALL be combinational: (bitmap not all ones) AND (outstanding_o < min(limit_i,NB_TID)).
REQ-018 tid_o SHALL be a combinational priority encode of the lowest clear bitmap bit; 0 when none is free.
REQ-019 Allocation: alloc_req_i=1 with valid_tid_o=1 sets bitmap[tid_o] at the next edge and increments the counter.
REQ-020 alloc_req_i=1 with valid_tid_o=0 SHALL be ignored, with no state change.
REQ-021 Release: release_req_i=1 clears bitmap[release_tid_i] at the next edge and decrements the counter, if the bit is set.
REQ-022 Simultaneous valid allocate and valid release SHALL apply both; the counter is unchanged and the bitmap shows both updates.
REQ-023 An ID released in cycle N SHALL NOT appear on tid_o before cycle N+1, because allocation uses the pre-edge bitmap.
REQ-024 release_tid_i >= NB_TID, or a release of a clear bit, SHALL be treated as an invalid release (see Configuration).
REQ-025 The counter SHALL never wrap; it stays within 0..NB_TID under all input sequences.
REQ-026 limit_i lowered below outstanding_o SHALL only block new allocations; existing IDs are unaffected.
REQ-027 limit_i=0 SHALL force valid_tid_o=0.
REQ-028 Latency: alloc or release to the updated outputs SHALL be exactly 1 cycle.

Reset
REQ-029 Reset SHALL set bitmap=0, counter=0 and err_o=0, giving idle_o=1, valid_tid_o=(limit_i!=0) and tid_o=0.
REQ-030 Reset mid-operation SHALL discard all outstanding IDs; releases arriving after reset are invalid releases.

Configuration
REQ-031 Macro EXT_TID_ALLOC_CHECK_EN defined: an invalid release changes no state and sets err_o at the next edge.
REQ-032 err_o SHALL hold until err_clr_i=1; if err_clr_i coincides with a new invalid release, err_o stays 1.
REQ-033 Macro EXT_TID_ALLOC_CHECK_EN undefined: an invalid release is ignored, err_o is constant 0 and err_clr_i is unused.

Verification
REQ-034 NB_TID=4, limit_i=4, alloc every cycle x5 -> tid_o 0,1,2,3, then valid_tid_o=0 and outstanding_o=4.
REQ-035 4 allocated, release tid 2 and alloc in the same cycle -> alloc is ignored (valid_tid_o was 0); next cycle tid_o=2 and outstanding_o=3.
REQ-036 IDs 0,1 allocated, alloc (tid 2) and release tid 0 in the same cycle -> outstanding_o=2, bitmap=0b0110, tid_o=0.
REQ-037 limit_i=2, 3 alloc requests -> the third is ignored; raising limit_i to 3 -> valid_tid_o=1 and tid_o=2.
REQ-038 CHECK_EN defined, release tid 3 when it is free -> err_o=1 next cycle and outstanding_o unchanged; err_clr_i -> err_o=0.
REQ-039 3 IDs outstanding, assert rst_ni low asynchronously mid-cycle -> outputs immediately idle_o=1 and outstanding_o=0.

Source files
------------

// File: rtl/ext_tid_alloc.sv
// Transaction-ID pool: busy bitmap, outstanding counter and a soft limit on live IDs.
// Define EXT_TID_ALLOC_CHECK_EN to turn invalid releases into a sticky err_o flag.
module ext_tid_alloc #(
    parameter int NB_TID        = 16,
    parameter int EXT_TID_WIDTH = 4,
    parameter int CNT_WIDTH     = EXT_TID_WIDTH + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [CNT_WIDTH-1:0]     limit_i,
    input  logic                     alloc_req_i,
    output logic                     valid_tid_o,
    output logic [EXT_TID_WIDTH-1:0] tid_o,
    input  logic                     release_req_i,
    input  logic [EXT_TID_WIDTH-1:0] release_tid_i,
    output logic [CNT_WIDTH-1:0]     outstanding_o,
    output logic                     idle_o,
    output logic                     err_o,
    input  logic                     err_clr_i
);

    localparam int NB_PAD = 1 << EXT_TID_WIDTH;
    localparam logic [CNT_WIDTH-1:0] NB_TID_C = CNT_WIDTH'(NB_TID);

    logic [NB_TID-1:0]    busy_q;
    logic [NB_TID-1:0]    busy_d;
    logic [NB_TID-1:0]    set_mask;
    logic [NB_TID-1:0]    clr_mask;
    logic [NB_PAD-1:0]    busy_pad;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] eff_limit;
    logic                 alloc_fire;
    logic                 rel_valid;

    assign eff_limit   = (limit_i > NB_TID_C) ? NB_TID_C : limit_i;
    assign valid_tid_o = ~(&busy_q) && (cnt_q < eff_limit);

    always_comb begin
        tid_o = '0;
        for (int i = NB_TID - 1; i >= 0; i--) begin
            if (!busy_q[i]) tid_o = EXT_TID_WIDTH'(i);
        end
    end

    // Padding to the full ID space makes out-of-range IDs read as free, so they fall out as invalid releases.
    assign busy_pad   = NB_PAD'(busy_q);
    assign rel_valid  = release_req_i & busy_pad[release_tid_i];
    assign alloc_fire = alloc_req_i & valid_tid_o;

    // The allocated ID is always free and the released one always busy, so the two masks never overlap.
    assign set_mask = alloc_fire ? (NB_TID'(1) << tid_o) : '0;
    assign clr_mask = rel_valid ? (NB_TID'(1) << release_tid_i) : '0;
    assign busy_d   = (busy_q | set_mask) & ~clr_mask;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            if (alloc_fire && !rel_valid) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!alloc_fire && rel_valid) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign outstanding_o = cnt_q;
    assign idle_o        = (cnt_q == '0);

`ifdef EXT_TID_ALLOC_CHECK_EN
    logic err_q;

    // A fresh invalid release wins over a coincident clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (release_req_i && !rel_valid) begin
            err_q <= 1'b1;
        end else if (err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr_i;
    assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_ext_tid_alloc.sv
// Scoreboard bench for ext_tid_alloc: directed corner cases then random traffic against a set-based model.
module tb_ext_tid_alloc;

    localparam int NB = 4;
    localparam int TW = 4;
    localparam int CW = 5;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [CW-1:0] limit_i = CW'(4);
    logic          alloc_req_i = 1'b0;
    logic          valid_tid_o;
    logic [TW-1:0] tid_o;
    logic          release_req_i = 1'b0;
    logic [TW-1:0] release_tid_i = '0;
    logic [CW-1:0] outstanding_o;
    logic          idle_o;
    logic          err_o;
    logic          err_clr_i = 1'b0;

    ext_tid_alloc #(.NB_TID(NB), .EXT_TID_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .limit_i(limit_i), .alloc_req_i(alloc_req_i),
        .valid_tid_o(valid_tid_o), .tid_o(tid_o), .release_req_i(release_req_i),
        .release_tid_i(release_tid_i), .outstanding_o(outstanding_o), .idle_o(idle_o),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          valid;
        logic [TW-1:0] tid;
        logic [CW-1:0] outstanding;
        logic          idle;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: the set of IDs currently handed out, plus the error flag.
    bit held[int];
    bit m_err = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < NB; i++) begin
            if (!held.exists(i)) return i;
        end
        return 0;
    endfunction

    function automatic bit model_valid(input int lim);
        int eff;
        eff = (lim > NB) ? NB : lim;
        return (held.num() < NB) && (held.num() < eff);
    endfunction

    task automatic applyStimulus(input bit alloc, input bit rel, input int rtid, input int lim, input bit clr);
        exp_t e;
        bit   pre_valid;
        int   pre_tid;
        bit   rel_ok;
        @(negedge clk_i);
        alloc_req_i   = alloc;
        release_req_i = rel;
        release_tid_i = TW'(rtid);
        limit_i       = CW'(lim);
        err_clr_i     = clr;
        pre_valid = model_valid(lim);
        pre_tid   = lowest_free();
        rel_ok    = rel && (rtid < NB) && held.exists(rtid);
        if (rel_ok) held.delete(rtid);
        if (alloc && pre_valid) held[pre_tid] = 1'b1;
`ifdef EXT_TID_ALLOC_CHECK_EN
        if (rel && !rel_ok) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
`else
        m_err = 1'b0;
`endif
        e.valid       = model_valid(lim);
        e.tid         = TW'(lowest_free());
        e.outstanding = CW'(held.num());
        e.idle        = (held.num() == 0);
        e.err         = m_err;
        exp_q.push_back(e);
    endtask

    task automatic checkReset();
        checkOutput("rst_idle", idle_o, 1);
        checkOutput("rst_outstanding", outstanding_o, 0);
        checkOutput("rst_tid", tid_o, 0);
        checkOutput("rst_valid", valid_tid_o, limit_i != 0);
        checkOutput("rst_err", err_o, 0);
    endtask

    // Drop reset in the middle of the high phase and look at the outputs before any clock edge.
    task automatic asyncReset();
        @(posedge clk_i);
        #3;
        rst_ni        = 1'b0;
        alloc_req_i   = 1'b0;
        release_req_i = 1'b0;
        err_clr_i     = 1'b0;
        #1;
        checkReset();
        held.delete();
        m_err = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("valid_tid", valid_tid_o, e.valid);
                checkOutput("tid", tid_o, e.tid);
                checkOutput("outstanding", outstanding_o, e.outstanding);
                checkOutput("idle", idle_o, e.idle);
                checkOutput("err", err_o, e.err);
            end
        end
    end

    initial begin : driver
        int r;
        int lim;
        #13;
        checkReset();
        @(negedge clk_i);
        rst_ni = 1'b1;

        repeat (5) applyStimulus(1, 0, 0, 4, 0);
        applyStimulus(1, 1, 2, 4, 0);
        applyStimulus(0, 0, 0, 4, 0);

        asyncReset();
        repeat (2) applyStimulus(1, 0, 0, 4, 0);
        applyStimulus(1, 1, 0, 4, 0);

        asyncReset();
        repeat (3) applyStimulus(1, 0, 0, 2, 0);
        applyStimulus(0, 0, 0, 3, 0);
        applyStimulus(0, 1, 3, 3, 0);
        applyStimulus(0, 0, 0, 3, 1);
        applyStimulus(0, 1, 3, 3, 1);
        applyStimulus(0, 0, 0, 3, 1);
        applyStimulus(0, 1, 9, 4, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 31, 0);

        asyncReset();
        repeat (3) applyStimulus(1, 0, 0, 4, 0);
        asyncReset();
        applyStimulus(0, 1, 0, 4, 0);
        applyStimulus(0, 0, 0, 4, 1);

        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) lim = 0;
            else if (r < 3) lim = $urandom_range(1, 3);
            else lim = $urandom_range(4, 6);
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 5), lim, $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 99) == 0) asyncReset();
        end

        repeat (3) @(posedge clk_i);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
